// File: rtl/tt_sweep_pkg.sv
// Shared types and sizing helpers for the truth-table sweep controller.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Wait counter must hold SETTLE; a zero-settle build still needs one bit.
    function automatic int wait_width(input int settle);
        int w;
        w = $clog2(settle + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that times the hold period of each input code.
module tt_settle_timer
    import tt_sweep_pkg::*;
#(
    parameter int SETTLE = 1,
    parameter int W      = wait_width(SETTLE)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic load,
    input  logic dec,
    output logic wait_zero
);

    logic [W-1:0] cnt_r;

    // Hold-time counter: clear wins over load, load wins over decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= W'(SETTLE);
        end else if (dec && (cnt_r != '0)) begin
            cnt_r <= cnt_r - W'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign wait_zero = (cnt_r == '0);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Walks a combinational block through every input code, samples its output
// after a settle time and accumulates the truth table and its popcount.
module tt_sweep_ctrl
    import tt_sweep_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   f_in,
    output logic [N_IN-1:0]        vec_out,
    output logic                   busy,
    output logic                   done,
    output logic                   valid,
    output logic [(1<<N_IN)-1:0]   tt_out,
    output logic [N_IN:0]          ones_cnt
);

    localparam int NCODE = 1 << N_IN;
    localparam logic [N_IN-1:0] LAST_CODE = {N_IN{1'b1}};

    state_t             state_r;
    state_t             state_s;
    logic [N_IN-1:0]    vec_s;
    logic               busy_s;
    logic               done_s;
    logic               valid_s;
    logic [NCODE-1:0]   tt_s;
    logic [N_IN:0]      cnt_s;
    logic               load_s;
    logic               dec_s;
    logic               clear_s;
    logic               wait_zero_s;

    tt_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear_s),
        .load      (load_s),
        .dec       (dec_s),
        .wait_zero (wait_zero_s)
    );

    // Next-state and next-output decode for the sweep sequencer.
    always_comb begin
        state_s = state_r;
        vec_s   = vec_out;
        busy_s  = busy;
        done_s  = 1'b0;
        valid_s = valid;
        tt_s    = tt_out;
        cnt_s   = ones_cnt;
        load_s  = 1'b0;
        dec_s   = 1'b0;
        clear_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (abort) begin
                    valid_s = 1'b0;
                    tt_s    = '0;
                    cnt_s   = '0;
                end else if (start) begin
                    state_s = ST_RUN;
                    vec_s   = '0;
                    busy_s  = 1'b1;
                    valid_s = 1'b0;
                    tt_s    = '0;
                    cnt_s   = '0;
                    load_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_s = ST_IDLE;
                    vec_s   = '0;
                    busy_s  = 1'b0;
                    valid_s = 1'b0;
                    tt_s    = '0;
                    cnt_s   = '0;
                    clear_s = 1'b1;
                end else if (!wait_zero_s) begin
                    dec_s = 1'b1;
                end else begin
                    // Code has settled: capture it, then advance or finish.
                    tt_s[vec_out] = f_in;
                    cnt_s         = ones_cnt + {{N_IN{1'b0}}, f_in};
                    if (vec_out == LAST_CODE) begin
                        state_s = ST_DONE;
                        vec_s   = '0;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                        valid_s = 1'b1;
                    end else begin
                        vec_s  = vec_out + N_IN'(1'b1);
                        load_s = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                if (abort) begin
                    valid_s = 1'b0;
                    tt_s    = '0;
                    cnt_s   = '0;
                end else begin
                    valid_s = valid;
                end
            end
            default: begin
                state_s = ST_IDLE;
                vec_s   = '0;
                busy_s  = 1'b0;
                valid_s = 1'b0;
                tt_s    = '0;
                cnt_s   = '0;
                clear_s = 1'b1;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_out  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            valid    <= 1'b0;
            tt_out   <= '0;
            ones_cnt <= '0;
        end else begin
            vec_out  <= vec_s;
            busy     <= busy_s;
            done     <= done_s;
            valid    <= valid_s;
            tt_out   <= tt_s;
            ones_cnt <= cnt_s;
        end
    end

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: two instances (SETTLE=0 and SETTLE=2) checked every
// cycle against a cycle-count model, plus directed literal expectations.
module tb_tt_sweep_ctrl;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       start_v;
    logic [1:0]       abort_v;
    logic [1:0]       f_v;
    logic [1:0]       busy_v;
    logic [1:0]       done_v;
    logic [1:0]       valid_v;
    logic [1:0][3:0]  vec_v;
    logic [1:0][15:0] tt_v;
    logic [1:0][4:0]  cnt_v;
    int               mode [2];
    int               checks = 0;
    int               failures = 0;

    logic             m_run   [2];
    logic             m_done  [2];
    logic             m_valid [2];
    int               m_k     [2];
    logic [15:0]      m_tt    [2];

    always #5 clk = ~clk;

    function automatic logic f_of(input int m, input logic [3:0] c);
        case (m)
            0:       return c[2] & (c[3] | ~c[1]);
            1:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int settle_of(input int i);
        return (i == 0) ? 0 : 2;
    endfunction

    assign f_v[0] = f_of(mode[0], vec_v[0]);
    assign f_v[1] = f_of(mode[1], vec_v[1]);

    tt_sweep_ctrl #(.N_IN(4), .SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
        .f_in(f_v[0]), .vec_out(vec_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .valid(valid_v[0]), .tt_out(tt_v[0]), .ones_cnt(cnt_v[0])
    );

    tt_sweep_ctrl #(.N_IN(4), .SETTLE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
        .f_in(f_v[1]), .vec_out(vec_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .valid(valid_v[1]), .tt_out(tt_v[1]), .ones_cnt(cnt_v[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: m_k counts edges since the accepted start; code c is held for
    // steps c*(S+1) .. (c+1)*(S+1)-1 and sampled on the edge leaving that window.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_run[i]   <= 1'b0;
                m_done[i]  <= 1'b0;
                m_valid[i] <= 1'b0;
                m_k[i]     <= 0;
                m_tt[i]    <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_run[i]) begin
                    if (abort_v[i]) begin
                        m_run[i]   <= 1'b0;
                        m_valid[i] <= 1'b0;
                        m_tt[i]    <= 16'h0000;
                    end else begin
                        if (((m_k[i] + 1) % (settle_of(i) + 1)) == 0) begin
                            m_tt[i][m_k[i] / (settle_of(i) + 1)] <=
                                f_of(mode[i], 4'(m_k[i] / (settle_of(i) + 1)));
                            if ((m_k[i] / (settle_of(i) + 1)) == 15) begin
                                m_run[i]   <= 1'b0;
                                m_done[i]  <= 1'b1;
                                m_valid[i] <= 1'b1;
                            end
                        end
                        m_k[i] <= m_k[i] + 1;
                    end
                end else if (m_done[i]) begin
                    m_done[i] <= 1'b0;
                    if (abort_v[i]) begin
                        m_valid[i] <= 1'b0;
                        m_tt[i]    <= 16'h0000;
                    end
                end else if (abort_v[i]) begin
                    m_valid[i] <= 1'b0;
                    m_tt[i]    <= 16'h0000;
                end else if (start_v[i]) begin
                    m_run[i]   <= 1'b1;
                    m_k[i]     <= 0;
                    m_valid[i] <= 1'b0;
                    m_tt[i]    <= 16'h0000;
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("dut%0d.vec_out", i), 32'(vec_v[i]),
                m_run[i] ? 32'(m_k[i] / (settle_of(i) + 1)) : 32'd0);
            chk($sformatf("dut%0d.busy", i), 32'(busy_v[i]), 32'(m_run[i]));
            chk($sformatf("dut%0d.done", i), 32'(done_v[i]), 32'(m_done[i]));
            chk($sformatf("dut%0d.valid", i), 32'(valid_v[i]), 32'(m_valid[i]));
            chk($sformatf("dut%0d.tt_out", i), 32'(tt_v[i]), 32'(m_tt[i]));
            chk($sformatf("dut%0d.ones_cnt", i), 32'(cnt_v[i]), 32'($countones(m_tt[i])));
        end
    end

    // Pulse start, optionally poke start again when vec_out==poke, and measure
    // edges from the start-capturing edge to done.
    task automatic sweep(input int i, input int exp_edges, input int poke);
        int n;
        bit poked;
        @(negedge clk); #1 start_v[i] = 1'b1;
        @(negedge clk); #1 start_v[i] = 1'b0;
        n = 0;
        poked = 1'b0;
        while (n < 300) begin
            @(negedge clk);
            n++;
            if (done_v[i]) break;
            #1;
            if (!poked && poke >= 0 && int'(vec_v[i]) == poke) begin
                start_v[i] = 1'b1;
                poked = 1'b1;
            end else begin
                start_v[i] = 1'b0;
            end
        end
        chk($sformatf("dut%0d done latency", i), 32'(n), 32'(exp_edges));
        #1 start_v[i] = 1'b0;
    endtask

    task automatic chk_result(input string tag, input int i, input logic [15:0] tt,
                              input int ones);
        chk({tag, " tt_out"}, 32'(tt_v[i]), 32'(tt));
        chk({tag, " ones_cnt"}, 32'(cnt_v[i]), 32'(ones));
        chk({tag, " valid"}, 32'(valid_v[i]), 32'd1);
        chk({tag, " busy"}, 32'(busy_v[i]), 32'd0);
    endtask

    initial begin
        int n;
        rst_n   = 1'b0;
        start_v = 2'b00;
        abort_v = 2'b00;
        mode[0] = 0;
        mode[1] = 0;
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy_v), 32'd0);
        chk("reset valid", 32'(valid_v), 32'd0);
        chk("reset vec", 32'(vec_v), 32'd0);
        chk("reset tt", 32'(tt_v[0]), 32'd0);
        #1 rst_n = 1'b1;

        sweep(0, 16, -1);
        chk_result("f settle0", 0, 16'hF030, 6);
        sweep(1, 48, -1);
        chk_result("f settle2", 1, 16'hF030, 6);

        mode[0] = 1;
        sweep(0, 16, -1);
        chk_result("const1", 0, 16'hFFFF, 16);
        mode[0] = 2;
        sweep(0, 16, -1);
        chk_result("const0", 0, 16'h0000, 0);

        // Abort while code 7 is applied.
        mode[0] = 0;
        @(negedge clk); #1 start_v[0] = 1'b1;
        @(negedge clk); #1 start_v[0] = 1'b0;
        n = 0;
        while (vec_v[0] != 4'd7 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("abort reach code 7", 32'(vec_v[0]), 32'd7);
        #1 abort_v[0] = 1'b1;
        @(negedge clk);
        chk("abort busy", 32'(busy_v[0]), 32'd0);
        chk("abort valid", 32'(valid_v[0]), 32'd0);
        chk("abort tt", 32'(tt_v[0]), 32'd0);
        chk("abort done", 32'(done_v[0]), 32'd0);
        #1 abort_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        sweep(0, 16, -1);
        chk_result("after abort", 0, 16'hF030, 6);

        // Start re-asserted mid-sweep must not disturb timing.
        sweep(0, 16, 3);
        chk_result("mid start", 0, 16'hF030, 6);

        // Start and abort together in IDLE.
        @(negedge clk); #1 begin start_v[0] = 1'b1; abort_v[0] = 1'b1; end
        @(negedge clk);
        chk("start+abort busy", 32'(busy_v[0]), 32'd0);
        chk("start+abort valid", 32'(valid_v[0]), 32'd0);
        #1 begin start_v[0] = 1'b0; abort_v[0] = 1'b0; end
        repeat (3) @(negedge clk);

        // Asynchronous reset between edges mid-sweep.
        @(negedge clk); #1 start_v[0] = 1'b1;
        @(negedge clk); #1 start_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1 chk("pre-reset busy", 32'(busy_v[0]), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async rst busy", 32'(busy_v), 32'd0);
        chk("async rst vec", 32'(vec_v), 32'd0);
        chk("async rst done", 32'(done_v), 32'd0);
        chk("async rst valid", 32'(valid_v), 32'd0);
        chk("async rst tt", 32'(tt_v[0]), 32'd0);
        chk("async rst cnt", 32'(cnt_v[0]), 32'd0);
        @(negedge clk); #1 rst_n = 1'b1;
        sweep(0, 16, -1);
        chk_result("after reset", 0, 16'hF030, 6);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tt_sweep_ctrl.md
Name: tt_sweep_ctrl

Overview:
- Sequencer that drives a small combinational logic block through every input code 0..2^N_IN-1.
- Waits a programmable settle time per code, samples the block's single output, and builds the full truth table plus a count of ones.
- Sits between the lab's combinational function under test and a host or bench using a start/busy/done handshake.
- Replaces the free-running delay-loop stimulus with a synchronous, self-checking-friendly sweep.

Parameters:
- N_IN, 4, number of function inputs; the sweep covers 2^N_IN codes.
- SETTLE, 1, extra hold cycles per code before sampling (0 = sample on the first edge after the code is applied).

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a sweep; sampled only in IDLE
- abort  in  1  cancel a sweep in progress
- f_in  in  1  output of the combinational block under test
- vec_out  out  N_IN  input code driven to the block; MSB is the first input (a), LSB the last (d)
- busy  out  1  high while sweeping
- done  out  1  one-cycle pulse when the sweep completes
- valid  out  1  tt_out/ones_cnt hold a complete result
- tt_out  out  2^N_IN  tt_out[k] = f_in sampled with vec_out==k
- ones_cnt  out  N_IN+1  number of 1s in tt_out

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, vec_out=0, busy=0, done=0, valid=0, tt_out=0, ones_cnt=0, wait counter=0.
- States:
  - IDLE: start=1 and abort=0 at an edge → RUN; vec_out=0, wait=SETTLE, tt_out=0, ones_cnt=0, valid=0, busy=1.
  - RUN, wait!=0: wait decrements; vec_out is held.
  - RUN, wait==0: tt_out[vec_out] <= f_in and ones_cnt += f_in. If vec_out==2^N_IN-1 → DONE; otherwise vec_out++ and wait=SETTLE.
  - DONE: lasts exactly one cycle. done=1, busy=0, valid=1, vec_out returns to 0, then → IDLE.
- Latency: done rises 2^N_IN*(SETTLE+1) edges after the edge that captured start. Each code is held exactly SETTLE+1 cycles.
- Results: tt_out, ones_cnt and valid hold until the next accepted start or an abort.
- start while RUN or DONE: ignored, no queuing.
- abort in RUN: next edge → IDLE. vec_out=0, busy=0, tt_out=0, ones_cnt=0, valid=0; no done pulse.
- abort in IDLE or DONE: clears valid, tt_out and ones_cnt; the state sequence is otherwise unchanged (DONE still pulses done).
- start and abort together in IDLE: abort wins; stay in IDLE.
- Reset asserted mid-sweep: all outputs go to reset values immediately (asynchronous); no done pulse.
- Width rules:
  - ones_cnt is N_IN+1 bits so 2^N_IN cannot overflow.
  - vec_out increments without wrap; the terminal code is detected explicitly.
  - The wait counter is clog2(SETTLE+1) bits, minimum 1.
- f_in is treated as synchronous to clk, combinationally derived from vec_out; no synchroniser.

Decomposition:
- Shared package tt_sweep_pkg:
  - state enum {IDLE, RUN, DONE}
  - localparam function to compute the wait-counter width
- One natural sub-module, tt_settle_timer: loadable down-counter with a zero flag. Loaded with SETTLE, decrements in RUN, flags wait==0.
- Everything else is inline in tt_sweep_ctrl.

Test Plan:
- Bench model f = b&(a|~c), SETTLE=0, pulse start → done 16 edges after the start edge; tt_out=16'hF030, ones_cnt=6, valid=1, busy=0.
- Same function, SETTLE=2 → each code held 3 cycles; done after 48 edges; tt_out=16'hF030.
- f=1 constant, SETTLE=0 → tt_out=16'hFFFF, ones_cnt=16 (no overflow); f=0 → tt_out=0, ones_cnt=0, valid=1.
- Assert abort while vec_out==7 → next edge IDLE, busy=0, valid=0, tt_out=0, no done pulse. A following start → full correct sweep.
- Pulse start at vec_out==3 mid-sweep → ignored, done timing unchanged. start and abort in the same IDLE cycle → stays IDLE, busy=0.
- Drop rst_n asynchronously mid-sweep (between edges) → all outputs 0 immediately. Release rst_n, then start → normal 16-edge sweep.
